// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, loader states and slot placement
// used by the loader and the fetch-side muxes
package imem_pkg;

  localparam int LINE_W         = 64;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  // Slot k lives at [63-16k:48-16k]; returns the lsb of that range
  function automatic logic [5:0] slot_lsb(
    input logic [1:0] k
  );
    return 6'(LINE_W - WORD_W) - {k, 4'b0000};
  endfunction

endpackage

// File: rtl/imem_line_packer.sv
// imem_line_packer: 4-slot line buffer with PAD fill
// o_line is the buffer with the word being pushed merged in
module imem_line_packer
  import imem_pkg::*;
#(
  parameter logic [WORD_W-1:0] PAD_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic              i_flush,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_line_full,
  output logic [LINE_W-1:0] o_line
);

  logic [1:0]        r_cnt;
  logic [LINE_W-1:0] r_buf;
  logic [LINE_W-1:0] w_line;

  assign o_line_full = (r_cnt == 2'd3);
  assign o_line      = w_line;

  always_comb begin
    w_line = r_buf;
    if (i_push) begin
      w_line[slot_lsb(r_cnt) +: WORD_W] = i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (i_clear || (i_push && i_flush)) begin
      r_cnt <= '0;
      r_buf <= {WORDS_PER_LINE{PAD_WORD}};
    end else if (i_push) begin
      r_buf[slot_lsb(r_cnt) +: WORD_W] <= i_data;
      r_cnt <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams 16-bit words into 64-bit imem lines
// and holds the core in start until the image is written
module imem_loader
  import imem_pkg::*;
#(
  parameter int                LINE_AW  = 14,
  parameter logic [WORD_W-1:0] PAD_WORD = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  input  logic [LINE_AW-1:0] base_line,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               wr_en,
  output logic [LINE_AW-1:0] wr_addr,
  output logic [LINE_W-1:0]  wr_data,
  output logic               start,
  output logic               done,
  output logic               err,
  output logic [LINE_AW+1:0] words_loaded
);

  ld_state_e          r_state;
  logic [LINE_AW-1:0] r_ptr;
  logic               r_in_ready;
  logic               r_wr_en;
  logic [LINE_AW-1:0] r_wr_addr;
  logic [LINE_W-1:0]  r_wr_data;
  logic               r_start;
  logic               r_done;
  logic               r_err;
  logic [LINE_AW+1:0] r_words;

  logic              w_accept;
  logic              w_full;
  logic              w_flush;
  logic              w_clear;
  logic [LINE_W-1:0] w_line;

  assign w_accept = (r_state == ST_LOAD)
                  & in_valid & r_in_ready;
  assign w_flush  = w_accept & (w_full | in_last);
  assign w_clear  = load_req & (r_state != ST_LOAD);

  imem_line_packer #(
    .PAD_WORD (PAD_WORD)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_push      (w_accept),
    .i_flush     (w_flush),
    .i_data      (in_data),
    .o_line_full (w_full),
    .o_line      (w_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_start    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        ST_LOAD: begin
          if (w_flush) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ptr;
            r_wr_data <= w_line;
            if (in_last) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_start    <= 1'b0;
              r_in_ready <= 1'b0;
            end else if (&r_ptr) begin
              // top line written with more to come: no wrap
              r_state    <= ST_ERR;
              r_err      <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
          if (w_accept && !(&r_words)) begin
            r_words <= r_words + 1'b1;
          end
        end
        default: begin
          if (load_req) begin
            r_state    <= ST_LOAD;
            r_ptr      <= base_line;
            r_words    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_start    <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign start        = r_start;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + random loads against a line model
// a second small instance covers overflow and PAD fill
module tb_imem_loader;
  import imem_pkg::*;

  localparam int          AW   = 14;
  localparam int          SAW  = 2;
  localparam logic [15:0] SPAD = 16'hDEAD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          load_req  = 1'b0;
  logic [AW-1:0] base_line = '0;
  logic          in_valid  = 1'b0;
  logic [15:0]   in_data   = '0;
  logic          in_last   = 1'b0;
  logic          in_ready, wr_en, start, done, err;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [AW+1:0] words_loaded;

  logic           s_load_req  = 1'b0;
  logic [SAW-1:0] s_base_line = '0;
  logic           s_in_valid  = 1'b0;
  logic [15:0]    s_in_data   = '0;
  logic           s_in_last   = 1'b0;
  logic           s_in_ready, s_wr_en, s_start, s_done, s_err;
  logic [SAW-1:0] s_wr_addr;
  logic [63:0]    s_wr_data;
  logic [SAW+1:0] s_words_loaded;

  imem_loader #(.LINE_AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_req(load_req), .base_line(base_line),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start),
    .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  imem_loader #(.LINE_AW(SAW), .PAD_WORD(SPAD)) u_small (
    .clk(clk), .rst_n(rst_n),
    .load_req(s_load_req), .base_line(s_base_line),
    .in_valid(s_in_valid), .in_data(s_in_data),
    .in_last(s_in_last), .in_ready(s_in_ready),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .start(s_start),
    .done(s_done), .err(s_err),
    .words_loaded(s_words_loaded)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  wr_t         got0[$];
  wr_t         got1[$];
  logic [15:0] wq[$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) got0.push_back({wr_addr, wr_data});
    if (s_wr_en === 1'b1)
      got1.push_back({{(AW-SAW){1'b0}}, s_wr_addr, s_wr_data});
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_start", start, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
  endtask

  task automatic start_load(input bit sel, input logic [AW-1:0] b);
    if (sel) begin
      s_load_req  = 1'b1;
      s_base_line = b[SAW-1:0];
    end else begin
      load_req  = 1'b1;
      base_line = b;
    end
    step;
    load_req   = 1'b0;
    s_load_req = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [15:0] d,
                      input bit last, input int gap);
    for (int g = 0; g < gap; g++) begin
      chk("ready_in_gap", sel ? s_in_ready : in_ready, 1);
      step;
    end
    if (sel) begin
      s_in_valid = 1'b1; s_in_data = d; s_in_last = last;
    end else begin
      in_valid = 1'b1; in_data = d; in_last = last;
    end
    chk("ready_on_valid", sel ? s_in_ready : in_ready, 1);
    step;
    in_valid = 1'b0; in_last = 1'b0;
    s_in_valid = 1'b0; s_in_last = 1'b0;
  endtask

  // Expected lines: ceil(n/4) writes at base+i, slot k at [63-16k -: 16]
  task automatic check_model(input bit sel,
                             input logic [AW-1:0] b,
                             input logic [15:0] pad);
    int          nl;
    int          ng;
    logic [63:0] e;
    wr_t         g;
    nl = (wq.size() + 3) / 4;
    ng = sel ? got1.size() : got0.size();
    chk("num_writes", ng, nl);
    for (int i = 0; i < nl; i++) begin
      e = {4{pad}};
      for (int k = 0; k < 4; k++)
        if (4 * i + k < wq.size()) e[63-16*k -: 16] = wq[4*i+k];
      g = '0;
      if (i < ng) g = sel ? got1[i] : got0[i];
      chk("line_addr", g.addr, 64'(b) + 64'(i));
      chk("line_data", g.data, e);
    end
    chk("words_loaded", sel ? 64'(s_words_loaded)
                            : 64'(words_loaded), wq.size());
    got0.delete();
    got1.delete();
  endtask

  task automatic run_load(input bit sel, input logic [AW-1:0] b,
                          input bit gaps);
    start_load(sel, b);
    for (int i = 0; i < wq.size(); i++)
      send(sel, wq[i], i == wq.size() - 1,
           gaps ? int'($urandom_range(0, 3)) : 0);
    chk("wr_en_after_last", sel ? s_wr_en : wr_en, 1);
    chk("done_after_last", sel ? s_done : done, 1);
    chk("start_after_last", sel ? s_start : start, 0);
    chk("ready_after_last", sel ? s_in_ready : in_ready, 0);
    step;
    step;
    chk("done_sticky", sel ? s_done : done, 1);
    check_model(sel, b, sel ? SPAD : 16'h0000);
  endtask

  task automatic basic_load;
    wq.delete();
    for (int i = 1; i <= 8; i++) wq.push_back(16'h1000 + 16'(i));
    start_load(0, '0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        load_req  = 1'b1;
        base_line = 14'd9;
      end
      send(0, wq[i], i == 7, 0);
      load_req = 1'b0;
    end
    chk("basic_done", done, 1);
    chk("basic_start", start, 0);
    step;
    chk("basic_line0", got0.size() > 0 ? got0[0].data : '0,
        64'h1001_1002_1003_1004);
    chk("basic_line1", got0.size() > 1 ? got0[1].data : '0,
        64'h1005_1006_1007_1008);
    check_model(0, '0, 16'h0000);
  endtask

  logic [AW-1:0] rb;

  initial begin
    rst_n = 1'b0;
    step;
    chk_reset;
    #2 rst_n = 1'b1;
    step;

    in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
    repeat (3) step;
    chk("idle_ready", in_ready, 0);
    chk("idle_words", words_loaded, 0);
    chk("idle_writes", got0.size(), 0);
    chk("idle_done", done, 0);
    in_valid = 1'b0; in_last = 1'b0;

    basic_load;

    wq = '{16'h00A1, 16'h00A2, 16'h00A3};
    run_load(0, 14'd5, 0);

    wq.delete();
    for (int i = 0; i < 12; i++) wq.push_back(16'($urandom));
    rb = 14'($urandom_range(0, 16000));
    run_load(0, rb, 0);
    run_load(0, rb, 1);

    for (int t = 0; t < 4; t++) begin
      wq.delete();
      for (int i = 0; i < int'($urandom_range(1, 17)); i++)
        wq.push_back(16'($urandom));
      run_load(0, 14'($urandom_range(0, 16000)), 1);
    end

    start_load(0, '0);
    send(0, 16'h2001, 0, 0);
    send(0, 16'h2002, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset;
    repeat (3) step;
    chk("reset_no_write", got0.size(), 0);
    #2 rst_n = 1'b1;
    step;
    basic_load;

    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
    start_load(1, 14'd3);
    for (int i = 0; i < 4; i++) send(1, wq[i], 0, 0);
    chk("ovf_wr_en", s_wr_en, 1);
    chk("ovf_addr", s_wr_addr, 3);
    chk("ovf_err", s_err, 1);
    chk("ovf_start", s_start, 1);
    chk("ovf_ready", s_in_ready, 0);
    s_in_valid = 1'b1; s_in_data = 16'h5555;
    repeat (3) begin
      step;
      chk("ovf_ready_held", s_in_ready, 0);
    end
    s_in_valid = 1'b0;
    chk("ovf_err_sticky", s_err, 1);
    check_model(1, 14'd3, SPAD);

    wq = '{16'h0B01, 16'h0B02};
    start_load(1, 14'd1);
    chk("reload_err_clear", s_err, 0);
    send(1, wq[0], 0, 0);
    send(1, wq[1], 1, 0);
    chk("pad_done", s_done, 1);
    step;
    check_model(1, 14'd1, SPAD);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
